// File: rtl/tick_timer_arbiter_if.sv
// tick_timer_arbiter_if: request/grant/timing bundle between the requesters and the shared tick timer
interface tick_timer_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 8
);
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] dur;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    done;
    logic               busy;
    logic               tick;
    modport master (output req, dur, input gnt, done, busy, tick);
    modport slave  (input req, dur, output gnt, done, busy, tick);
endinterface

// File: rtl/tick_timer_arbiter.sv
// tick_timer_arbiter: free-running prescaled tick shared round-robin among NREQ duration timers
module tick_timer_arbiter #(
    parameter int NREQ = 4,
    parameter int DIV  = 500000,
    parameter int DW   = 8
) (
    input logic                 clk,
    input logic                 clr,
    tick_timer_arbiter_if.slave bus
);
    localparam int PW = $clog2(DIV);
    localparam int IW = $clog2(NREQ);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic            tick_q, tick_d;
    logic [DW-1:0]   rem_q, rem_d;
    logic [IW-1:0]   w_q, w_d, ptr_q, ptr_d, pick, w_next;
    logic            found;
    logic [NREQ-1:0] gnt_q, gnt_d, done_q, done_d;
    logic            busy_q, busy_d;
    assign w_next = (w_q == IW'(NREQ - 1)) ? '0 : w_q + 1'b1;
    // Prescaler wraps at DIV-1 and never realigns; tick is the registered wrap flag
    always_comb begin
        presc_d = (presc_q == PW'(DIV - 1)) ? '0 : presc_q + 1'b1;
        tick_d  = presc_q == PW'(DIV - 1);
    end
    // Round-robin search: first pending request at or after ptr, wrapping
    always_comb begin
        pick  = ptr_q;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && bus.req[(int'(ptr_q) + k) % NREQ]) begin
                pick  = IW'((int'(ptr_q) + k) % NREQ);
                found = 1'b1;
            end
        end
    end
    // Arbitration FSM; abort beats completion, done is raised together with entry into FIN
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        w_d     = w_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        case (state_q)
            IDLE: if (found) begin
                state_d = RUN;
                w_d     = pick;
                rem_d   = bus.dur[int'(pick)*DW +: DW];
                gnt_d   = NREQ'(1) << pick;
            end
            RUN: if (!bus.req[w_q]) begin
                state_d = IDLE;
                gnt_d   = '0;
                ptr_d   = w_next;
            end else if (rem_q == '0 || (tick_q && rem_q == DW'(1))) begin
                state_d = FIN;
                rem_d   = '0;
                done_d  = gnt_q;
            end else if (tick_q) begin
                rem_d = rem_q - 1'b1;
            end
            FIN: begin
                state_d = IDLE;
                gnt_d   = '0;
                ptr_d   = w_next;
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
    end
    // State and output registers; clr discards any in-flight timing without a done pulse
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
            presc_q <= '0;
            tick_q  <= 1'b0;
            rem_q   <= '0;
            w_q     <= '0;
            ptr_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            tick_q  <= tick_d;
            rem_q   <= rem_d;
            w_q     <= w_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end
    assign bus.gnt  = gnt_q;
    assign bus.done = done_q;
    assign bus.busy = busy_q;
    assign bus.tick = tick_q;
endmodule

// File: tb/tb_tick_timer_arbiter.sv
// tb_tick_timer_arbiter: directed and randomized checks of grant order, done timing, abort and reset
module tb_tick_timer_arbiter;
    localparam int NREQ = 4;
    localparam int DIV  = 4;
    localparam int DW   = 8;
    logic clk = 1'b0;
    logic clr = 1'b1;
    int   passes = 0;
    int   total  = 0;
    int   n      = 0;
    int   ptr_m  = 0;
    tick_timer_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();
    tick_timer_arbiter #(.NREQ(NREQ), .DIV(DIV), .DW(DW)) dut (.clk(clk), .clr(clr), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask
    // Clock edges since reset release; a tick is due on every DIV-th edge
    always @(posedge clk or posedge clr) n <= clr ? 0 : n + 1;
    // Every cycle: tick pattern, grant is zero/one-hot, done only for the owner
    always @(negedge clk) begin
        chk("tick", 32'(bus.tick), 32'(n > 0 && n % DIV == 0));
        chk("gnt_onehot0", 32'($onehot0(bus.gnt)), 32'd1);
        chk("done_in_gnt", 32'(bus.done & ~bus.gnt), 32'd0);
    end
    function automatic int winner(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++) if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        return 0;
    endfunction
    task automatic set_dur(input int i, input int v);
        bus.dur[i*DW +: DW] = DW'(v);
    endtask
    // Raise r in an IDLE cycle, expect the round-robin winner, then abort at abort_at or await done.
    // mode: 0 keep req, 1 drop winner after done, 2 drop all after done
    task automatic serve(input logic [NREQ-1:0] r, input int abort_at, input int mode);
        int w, d, c, lo, hi;
        logic [NREQ-1:0]    oh;
        logic [NREQ*DW-1:0] saved;
        bus.req = r;
        w  = winner(r, ptr_m);
        oh = NREQ'(1) << w;
        d  = int'(bus.dur[w*DW +: DW]);
        lo = (d == 0) ? 1 : (d - 1) * DIV + 1;
        hi = (d == 0) ? 2 : d * DIV + 1;
        @(negedge clk);
        chk("grant", 32'(bus.gnt), 32'(oh));
        chk("busy_run", 32'(bus.busy), 32'd1);
        saved   = bus.dur;
        bus.dur = ~saved;
        c = 0;
        while (c < hi + 2 && bus.done == '0) begin
            if (c == abort_at) begin
                bus.req[w] = 1'b0;
                bus.dur    = saved;
                @(negedge clk);
                chk("abort_gnt", 32'(bus.gnt), 32'd0);
                chk("abort_done", 32'(bus.done), 32'd0);
                chk("abort_busy", 32'(bus.busy), 32'd0);
                ptr_m = (w + 1) % NREQ;
                return;
            end
            @(negedge clk);
            c++;
        end
        bus.dur = saved;
        chk("done", 32'(bus.done), 32'(oh));
        chk("done_gnt", 32'(bus.gnt), 32'(oh));
        chk("done_min", 32'(c >= lo), 32'd1);
        chk("done_max", 32'(c <= hi), 32'd1);
        if (mode == 1) bus.req[w] = 1'b0;
        else if (mode == 2) bus.req = '0;
        @(negedge clk);
        chk("clear_gnt", 32'(bus.gnt), 32'd0);
        chk("clear_done", 32'(bus.done), 32'd0);
        chk("clear_busy", 32'(bus.busy), 32'd0);
        ptr_m = (w + 1) % NREQ;
    endtask
    initial begin
        bus.req = '0;
        bus.dur = '0;
        repeat (2) @(negedge clk);
        clr = 1'b0;
        // Idle after reset: ticks only
        repeat (12) begin
            @(negedge clk);
            chk("idle_gnt", 32'(bus.gnt), 32'd0);
            chk("idle_busy", 32'(bus.busy), 32'd0);
        end
        // Single request, dur=3
        set_dur(2, 3);
        serve(4'b0100, -1, 2);
        // Reset pointer, then all four held with dur=1: 0,1,2,3,0
        clr = 1'b1;
        ptr_m = 0;
        @(negedge clk);
        clr = 1'b0;
        for (int i = 0; i < NREQ; i++) set_dur(i, 1);
        for (int i = 0; i < 5; i++) serve(4'b1111, -1, (i == 4) ? 2 : 0);
        // Abort six cycles into a dur=5 grant, then pointer moves past the aborted owner
        set_dur(1, 5);
        serve(4'b0010, 6, 2);
        set_dur(1, 1);
        serve(4'b0111, -1, 2);
        // Zero duration at every tick phase
        set_dur(0, 0);
        for (int ph = 0; ph < DIV; ph++) begin
            repeat (ph) @(negedge clk);
            serve(4'b0001, -1, 2);
        end
        // Move pointer away from 0, then reset in the middle of a dur=6 run
        set_dur(2, 1);
        serve(4'b0100, -1, 2);
        set_dur(2, 6);
        bus.req = 4'b0100;
        @(negedge clk);
        chk("pre_clr_grant", 32'(bus.gnt), 32'b0100);
        repeat (2 * DIV - 1) @(negedge clk);
        clr = 1'b1;
        bus.req = '0;
        #1;
        chk("clr_gnt", 32'(bus.gnt), 32'd0);
        chk("clr_done", 32'(bus.done), 32'd0);
        chk("clr_busy", 32'(bus.busy), 32'd0);
        chk("clr_tick", 32'(bus.tick), 32'd0);
        ptr_m = 0;
        @(negedge clk);
        clr = 1'b0;
        repeat (20) begin
            @(negedge clk);
            chk("post_clr_done", 32'(bus.done), 32'd0);
            chk("post_clr_gnt", 32'(bus.gnt), 32'd0);
        end
        set_dur(1, 1);
        set_dur(3, 1);
        serve(4'b1010, -1, 2);
        // Randomized traffic against the round-robin/duration model
        for (int t = 0; t < 40; t++) begin
            logic [NREQ-1:0] r;
            int w, d, ab;
            for (int i = 0; i < NREQ; i++) set_dur(i, int'($urandom_range(0, 3)));
            r  = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            w  = winner(r, ptr_m);
            d  = int'(bus.dur[w*DW +: DW]);
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, (d > 1) ? (d - 1) * DIV : 0)) : -1;
            serve(r, ab, int'($urandom_range(0, 2)));
            if (bus.req == '0) repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
